multicycle_control_unit: RTL

Main control FSM of the multicycle MIPS CPU. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath select line and write enable: the 1-bit and 2-bit selector `selection` inputs, PC/IR/register/memory writes, and the ALU operation. It sits between the instruction register (opcode/funct fields) and the datapath, and is the only source of mux select signals.

---
 rtl/multicycle_control_unit_pkg.sv | 69 ++++++
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit_alu_op_decode.sv | 50 +++++
 rtl/multicycle_control_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_pkg
// Shared encodings for the multicycle MIPS control unit:
//   - FSM state codes (also exported on the debug `state` port)
//   - opcode / funct field constants
//   - ALUOp and PCSrc select codes
//   - ctrl_t: bundle of every datapath control line driven by the FSM
// -----------------------------------------------------------------------------
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_EXE_LS = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_AL  = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic    pc_write;
        logic    ir_write;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_b;
        logic    ext_sel;
        logic    reg_dst;
        logic    mem_to_reg;
        pc_src_e pc_src;
        alu_op_e alu_op;
        logic    halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Control-unit <-> datapath bundle.
//   master : the control unit (consumes IR fields + zero, drives controls)
//   slave  : the datapath side (drives IR fields + zero, consumes controls)
// Signals: opcode[5:0], funct[5:0], zero, PCWrite, IRWrite, RegWrite,
//          MemRead, MemWrite, ALUSrcB, ExtSel, RegDst, MemtoReg,
//          PCSrc[1:0], ALUOp[2:0], state[3:0] (debug), halted.
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrcB;
    logic       ExtSel;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       halted;

    modport master (
        input  opcode, funct, zero,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
               ALUSrcB, ExtSel, RegDst, MemtoReg, PCSrc, ALUOp,
               state, halted
    );

    modport slave (
        output opcode, funct, zero,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
               ALUSrcB, ExtSel, RegDst, MemtoReg, PCSrc, ALUOp,
               state, halted
    );
endinterface

// File: rtl/multicycle_control_unit_alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational ALU operation decoder.
//   opcode[5:0], funct[5:0] : instruction fields from the IR
//   alu_op[2:0]             : ALU operation for this instruction
//   legal                   : 1 when the instruction maps to a known ALU
//                             operation (R-type legality is judged by funct)
// -----------------------------------------------------------------------------
module alu_op_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output logic       legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latches.
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                legal  = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Main control FSM of the multicycle MIPS CPU. Walks each instruction through
// fetch / decode / execute / memory / write-back and drives every datapath
// select and write enable.
//   CLK   : rising-edge clock
//   Reset : asynchronous, active-high; forces the FSM to fetch
//   bus   : control bundle (master side), see multicycle_control_unit_if
// All outputs are combinational from (state, opcode, funct, zero).
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic                      CLK,
    input  logic                      Reset,
    multicycle_control_unit_if.master bus
);

    state_e  state_q;
    state_e  state_d;
    ctrl_t   ctrl;
    alu_op_e dec_alu_op;
    logic    dec_legal;
    logic    is_rtype;

    assign is_rtype = (bus.opcode == OP_RTYPE);

    alu_op_decode u_alu_op_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (Reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (bus.opcode)
                    // An R-type with an unknown funct falls back to a NOP.
                    OP_RTYPE:        state_d = dec_legal ? S_EXE_AL : S_IF;
                    OP_ADDI, OP_ORI: state_d = S_EXE_AL;
                    OP_LW, OP_SW:    state_d = S_EXE_LS;
                    OP_BEQ:          state_d = S_EXE_BR;
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_IF;  // j completes in decode; NOPs
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;  // S_WB_AL, S_WB_LD, S_EXE_BR, unused codes
        endcase
    end

    // Output decode
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_IF: begin
                ctrl.pc_write = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.pc_src   = PC_PLUS4;
            end
            S_ID: begin
                if (bus.opcode == OP_J) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_JUMP;
                end
            end
            // Write-back keeps the execute-stage ALU setup so ALUOut stays stable.
            S_EXE_AL, S_WB_AL: begin
                ctrl.alu_src_b = !is_rtype;
                ctrl.ext_sel   = (bus.opcode == OP_ADDI);
                ctrl.alu_op    = dec_alu_op;
                if (state_q == S_WB_AL) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = is_rtype;
                end
            end
            S_EXE_LS: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM: begin
                ctrl.mem_read  = (bus.opcode == OP_LW);
                ctrl.mem_write = (bus.opcode == OP_SW);
            end
            S_WB_LD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXE_BR: begin
                ctrl.alu_op   = ALU_SUB;
                ctrl.pc_src   = PC_BRANCH;
                ctrl.pc_write = bus.zero;  // taken only when rs == rt
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCWrite  = ctrl.pc_write;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.ALUSrcB  = ctrl.alu_src_b;
    assign bus.ExtSel   = ctrl.ext_sel;
    assign bus.RegDst   = ctrl.reg_dst;
    assign bus.MemtoReg = ctrl.mem_to_reg;
    assign bus.PCSrc    = ctrl.pc_src;
    assign bus.ALUOp    = ctrl.alu_op;
    assign bus.state    = state_q;
    assign bus.halted   = ctrl.halted;

endmodule
